// File: rtl/ms_pkg.sv
// Shared minesweeper definitions: grid geometry, cell encoding, controller states
// and a helper that extracts one 4-bit cell from a packed board.
package ms_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int NCELLS = ROWS * COLS;

    localparam logic [3:0] CELL_MINE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN_RST,
        ST_GEN_WAIT,
        ST_PLAY,
        ST_SWEEP,
        ST_CHECK,
        ST_WON,
        ST_LOST
    } state_t;

    function automatic logic [3:0] cell_at(input logic [4*NCELLS-1:0] board,
                                           input logic [5:0]          idx);
        return board[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/ms_neighbor_zero.sv
// Flags a cell whose in-grid 8-neighbourhood contains a revealed zero-count cell.
// Neighbours never wrap across row or column edges.
module ms_neighbor_zero (
    input  logic [5:0]   idx,
    input  logic [255:0] map_q,
    input  logic [63:0]  revealed,
    output logic         zero_nb
);
    import ms_pkg::*;

    always_comb begin
        int         r;
        int         c;
        logic [5:0] nidx;
        // NOTE: every combinational output and temporary gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        zero_nb = 1'b0;
        r       = 0;
        c       = 0;
        nidx    = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(idx[5:3]) + dr;
                c = int'(idx[2:0]) + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                    nidx = 6'(r * COLS + c);
                    if (revealed[nidx] && cell_at(map_q, nidx) == 4'd0) begin
                        zero_nb = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Minesweeper game controller: sequences map generation, owns the board state,
// applies reveal/flag commands, flood-fills zero regions and detects win/loss.
module game_ctrl #(
    parameter int GEN_RST_CYCLES = 4,
    parameter int ROWS           = 8,
    parameter int COLS           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    output logic         gen_rst,
    input  logic         map_ready,
    input  logic [255:0] map_flat,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [2:0]   cmd_row,
    input  logic [2:0]   cmd_col,
    output logic [255:0] map_q,
    output logic [63:0]  revealed,
    output logic [63:0]  flagged,
    output logic         busy,
    output logic         won,
    output logic         lost
);
    import ms_pkg::*;

    localparam int               CNT_W    = (GEN_RST_CYCLES > 1) ? $clog2(GEN_RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GEN_RST_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  gen_cnt_q, gen_cnt_d;
    logic [5:0]        sweep_idx_q, sweep_idx_d;
    logic              change_q, change_d;
    logic              ready_prev_q;
    logic [255:0]      map_d;
    logic [63:0]       rev_q, rev_d;
    logic [63:0]       flag_q, flag_d;

    logic [5:0]        cmd_idx;
    logic [3:0]        cmd_cell;
    logic              nb_zero;
    logic              sweep_hit;
    logic              all_done;

    assign cmd_idx  = 6'(int'(cmd_row) * COLS + int'(cmd_col));
    assign cmd_cell = cell_at(map_q, cmd_idx);

    ms_neighbor_zero u_nb (
        .idx      (sweep_idx_q),
        .map_q    (map_q),
        .revealed (rev_q),
        .zero_nb  (nb_zero)
    );

    assign sweep_hit = !rev_q[sweep_idx_q] && !flag_q[sweep_idx_q] &&
                       (cell_at(map_q, sweep_idx_q) != CELL_MINE) && nb_zero;

    // Won once every non-mine cell is revealed; flags play no part.
    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (!rev_q[i] && cell_at(map_q, 6'(i)) != CELL_MINE) begin
                all_done = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gen_cnt_d   = gen_cnt_q;
        sweep_idx_d = sweep_idx_q;
        change_d    = change_q;
        map_d       = map_q;
        rev_d       = rev_q;
        flag_d      = flag_q;

        if (new_game) begin
            state_d   = ST_GEN_RST;
            gen_cnt_d = CNT_LOAD;
            rev_d     = '0;
            flag_d    = '0;
        end else begin
            unique case (state_q)
                ST_GEN_RST: begin
                    if (gen_cnt_q == '0) state_d = ST_GEN_WAIT;
                    else                 gen_cnt_d = gen_cnt_q - 1'b1;
                end
                ST_GEN_WAIT: begin
                    if (map_ready && !ready_prev_q) begin
                        map_d   = map_flat;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cmd_valid) begin
                        if (cmd_op) begin
                            if (!rev_q[cmd_idx]) flag_d[cmd_idx] = ~flag_q[cmd_idx];
                        end else if (!rev_q[cmd_idx] && !flag_q[cmd_idx]) begin
                            rev_d[cmd_idx] = 1'b1;
                            if (cmd_cell == CELL_MINE) begin
                                state_d = ST_LOST;
                            end else if (cmd_cell == 4'd0) begin
                                state_d     = ST_SWEEP;
                                sweep_idx_d = '0;
                                change_d    = 1'b0;
                            end else begin
                                state_d = ST_CHECK;
                            end
                        end
                    end
                end
                ST_SWEEP: begin
                    if (sweep_hit) rev_d[sweep_idx_q] = 1'b1;
                    // A pass that revealed anything is repeated until one reveals nothing.
                    if (sweep_idx_q == 6'(NCELLS - 1)) begin
                        if (change_q || sweep_hit) begin
                            change_d    = 1'b0;
                            sweep_idx_d = '0;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        sweep_idx_d = sweep_idx_q + 1'b1;
                        change_d    = change_q | sweep_hit;
                    end
                end
                ST_CHECK: state_d = all_done ? ST_WON : ST_PLAY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gen_cnt_q    <= '0;
            sweep_idx_q  <= '0;
            change_q     <= 1'b0;
            ready_prev_q <= 1'b0;
            map_q        <= '0;
            rev_q        <= '0;
            flag_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            gen_cnt_q    <= gen_cnt_d;
            sweep_idx_q  <= sweep_idx_d;
            change_q     <= change_d;
            ready_prev_q <= map_ready;
            map_q        <= map_d;
            rev_q        <= rev_d;
            flag_q       <= flag_d;
        end
    end

    assign revealed  = rev_q;
    assign flagged   = flag_q;
    assign gen_rst   = (state_q == ST_GEN_RST);
    assign cmd_ready = (state_q == ST_PLAY);
    assign won       = (state_q == ST_WON);
    assign lost      = (state_q == ST_LOST);
    assign busy      = (state_q == ST_GEN_RST) || (state_q == ST_GEN_WAIT) ||
                       (state_q == ST_SWEEP)   || (state_q == ST_CHECK);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed handshake/flood/flag/restart/reset steps,
// then random games compared against a queue-based flood-fill reference model.
module tb_game_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         new_game = 1'b0;
    logic         map_ready = 1'b0;
    logic [255:0] map_flat = '0;
    logic         cmd_valid = 1'b0;
    logic         cmd_op = 1'b0;
    logic [2:0]   cmd_row = '0;
    logic [2:0]   cmd_col = '0;
    logic         gen_rst, cmd_ready, busy, won, lost;
    logic [255:0] map_q;
    logic [63:0]  revealed, flagged;

    always #5 clk = ~clk;

    game_ctrl #(.GEN_RST_CYCLES(4), .ROWS(8), .COLS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .new_game  (new_game),
        .gen_rst   (gen_rst),
        .map_ready (map_ready),
        .map_flat  (map_flat),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .map_q     (map_q),
        .revealed  (revealed),
        .flagged   (flagged),
        .busy      (busy),
        .won       (won),
        .lost      (lost)
    );

    logic [5:0]   nb_idx = '0;
    logic [255:0] nb_map = '0;
    logic [63:0]  nb_rev = '0;
    logic         nb_out;

    ms_neighbor_zero u_nb (
        .idx      (nb_idx),
        .map_q    (nb_map),
        .revealed (nb_rev),
        .zero_nb  (nb_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (2-D grid, worklist flood fill) ----------------
    int m_map [64];
    bit m_rev [64];
    bit m_flag[64];
    bit m_lost, m_won;

    function automatic bit in_grid(input int r, input int c);
        return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
    endfunction

    function automatic logic [63:0] rev_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < 64; i++) v[i] = m_rev[i];
        return v;
    endfunction

    function automatic logic [63:0] flag_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < 64; i++) v[i] = m_flag[i];
        return v;
    endfunction

    task automatic model_load(input logic [255:0] m);
        for (int i = 0; i < 64; i++) begin
            m_map[i]  = int'(m[i*4 +: 4]);
            m_rev[i]  = 1'b0;
            m_flag[i] = 1'b0;
        end
        m_lost = 1'b0;
        m_won  = 1'b0;
    endtask

    task automatic model_flood();
        int q[$];
        int p, n;
        for (int i = 0; i < 64; i++) if (m_rev[i] && m_map[i] == 0) q.push_back(i);
        while (q.size() > 0) begin
            p = q.pop_front();
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if ((dr != 0 || dc != 0) && in_grid(p / 8 + dr, p % 8 + dc)) begin
                        n = (p / 8 + dr) * 8 + (p % 8 + dc);
                        if (!m_rev[n] && !m_flag[n] && m_map[n] != 15) begin
                            m_rev[n] = 1'b1;
                            if (m_map[n] == 0) q.push_back(n);
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_cmd(input bit op, input int row, input int col);
        int i = row * 8 + col;
        if (op) begin
            if (!m_rev[i]) m_flag[i] = !m_flag[i];
        end else if (!m_rev[i] && !m_flag[i]) begin
            m_rev[i] = 1'b1;
            if (m_map[i] == 15) begin
                m_lost = 1'b1;
            end else begin
                if (m_map[i] == 0) model_flood();
                m_won = 1'b1;
                for (int k = 0; k < 64; k++) if (!m_rev[k] && m_map[k] != 15) m_won = 1'b0;
            end
        end
    endtask

    function automatic bit nb_model(input int idx, input logic [255:0] map, input logic [63:0] rev);
        int n;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && in_grid(idx / 8 + dr, idx % 8 + dc)) begin
                    n = (idx / 8 + dr) * 8 + (idx % 8 + dc);
                    if (rev[n] && map[n*4 +: 4] == 4'd0) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [255:0] make_random_map(input int nmines);
        bit          mine[64];
        int          placed = 0;
        int          p, cnt;
        logic [255:0] m = '0;
        for (int i = 0; i < 64; i++) mine[i] = 1'b0;
        while (placed < nmines) begin
            p = $urandom_range(0, 63);
            if (!mine[p]) begin
                mine[p] = 1'b1;
                placed++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if ((dr != 0 || dc != 0) && in_grid(i / 8 + dr, i % 8 + dc))
                        if (mine[(i / 8 + dr) * 8 + (i % 8 + dc)]) cnt++;
            m[i*4 +: 4] = mine[i] ? 4'hF : 4'(cnt);
        end
        return m;
    endfunction

    // ---------------- DUT driving helpers (called at a falling edge) ----------------
    task automatic do_cmd(input bit op, input int row, input int col);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = 3'(row);
        cmd_col   = 3'(col);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_settle(input string tag, output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 2000; k++) begin
            if (cmd_ready || won || lost) break;
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        chk({tag, "_settle"}, cmd_ready | won | lost, 1);
    endtask

    task automatic start_game(input logic [255:0] m);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (!gen_rst) break;
            @(negedge clk);
        end
        map_flat  = m;
        map_ready = 1'b0;
        @(negedge clk);
        map_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        chk("start_ready", cmd_ready, 1);
        model_load(m);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] map_a, map_b, map_c, rmap;
        int cnt, bc;
        int t_idx[10] = '{0, 0, 0, 7, 7, 56, 56, 63, 63, 63};
        int t_rev[10] = '{63, 9, 1, 8, 15, 55, 49, 0, 54, 56};
        bit op;
        int row, col;

        map_a = '0;
        map_a[3:0]   = 4'hF;
        map_a[7:4]   = 4'h1;
        map_a[35:32] = 4'h1;
        map_a[39:36] = 4'h1;

        map_b = '0;
        map_b[63*4 +: 4] = 4'hF;
        map_b[54*4 +: 4] = 4'h1;
        map_b[55*4 +: 4] = 4'h1;
        map_b[62*4 +: 4] = 4'h1;

        map_c = '0;
        for (int i = 0; i < 64; i++) map_c[i*4 +: 4] = (i % 8 < 2) ? 4'h0 : (i % 8 == 2) ? 4'h1 : 4'h2;
        map_c[63*4 +: 4] = 4'hF;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {gen_rst, busy, won, lost, cmd_ready}, 0);
        chk("reset_map", map_q, 0);
        chk("reset_rev_flag", {revealed, flagged}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ctrl", {gen_rst, busy, cmd_ready}, 0);

        // Generation handshake with a stub that holds ready high throughout
        map_flat  = map_a;
        map_ready = 1'b1;
        new_game  = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!gen_rst) break;
            cnt++;
            @(negedge clk);
        end
        chk("gen_rst_len", cnt, 4);
        repeat (3) @(negedge clk);
        chk("no_level_latch", map_q, 0);
        chk("gen_wait_busy", {busy, cmd_ready}, 2'b10);
        map_ready = 1'b0;
        repeat (10) @(negedge clk);
        map_ready = 1'b1;
        @(negedge clk);
        chk("latched_map", map_q, map_a);
        chk("play_after_latch", {busy, cmd_ready}, 2'b01);
        model_load(map_a);

        // Nonzero reveal, then mine loss
        do_cmd(0, 0, 1);
        model_cmd(0, 0, 1);
        chk("reveal_T1", revealed, 64'h2);
        chk("check_state_T1", {busy, cmd_ready}, 2'b10);
        @(negedge clk);
        chk("play_T2", {cmd_ready, won, lost}, 3'b100);
        do_cmd(0, 0, 0);
        model_cmd(0, 0, 0);
        chk("mine_lost", {lost, revealed[0], cmd_ready}, 3'b110);
        chk("mine_rev", revealed, rev_vec());
        do_cmd(1, 2, 2);
        chk("lost_frozen", {lost, flagged}, {1'b1, 64'h0});

        // Flags on the flood map
        start_game(map_b);
        do_cmd(1, 3, 3);
        model_cmd(1, 3, 3);
        chk("flag_set", flagged, 64'd1 << 27);
        do_cmd(0, 3, 3);
        model_cmd(0, 3, 3);
        chk("flagged_no_reveal", {revealed, cmd_ready}, {64'h0, 1'b1});
        do_cmd(0, 0, 0);
        model_cmd(0, 0, 0);
        wait_settle("flood_flag", bc);
        chk("flood_flag_rev", revealed, 64'h7FFF_FFFF_F7FF_FFFF);
        chk("flood_flag_model", revealed, rev_vec());
        chk("flood_flag_nowin", {won, cmd_ready}, 2'b01);
        chk("flood_flag_busy", bc % 64, 1);
        do_cmd(1, 3, 3);
        chk("flag_clear", flagged, 0);

        // Full flood fill to a win
        start_game(map_b);
        do_cmd(0, 0, 0);
        model_cmd(0, 0, 0);
        wait_settle("flood", bc);
        chk("flood_rev", revealed, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("flood_won", {won, lost, cmd_ready}, {m_won, 2'b00});
        chk("flood_busy_mod", bc % 64, 1);
        chk("flood_two_pass", bc >= 129, 1);

        // No wrap across the row boundary
        start_game(map_c);
        do_cmd(0, 0, 0);
        model_cmd(0, 0, 0);
        wait_settle("edge", bc);
        chk("edge_rev", revealed, 64'h0707_0707_0707_0707);
        chk("edge_col7", revealed & 64'h8080_8080_8080_8080, 0);
        chk("edge_model", revealed, rev_vec());

        // Neighbour detector: corners, then random patterns
        nb_map = '0;
        for (int t = 0; t < 10; t++) begin
            nb_idx = 6'(t_idx[t]);
            nb_rev = 64'd1 << t_rev[t];
            #1;
            chk($sformatf("nb_corner_%0d_%0d", t_idx[t], t_rev[t]), nb_out, nb_model(t_idx[t], nb_map, nb_rev));
        end
        nb_map[9*4 +: 4] = 4'h2;
        nb_idx = 6'd0;
        nb_rev = 64'd1 << 9;
        #1;
        chk("nb_nonzero_nb", nb_out, 0);
        for (int t = 0; t < 40; t++) begin
            nb_idx = 6'($urandom_range(0, 63));
            nb_rev = {$urandom, $urandom} & {$urandom, $urandom};
            for (int i = 0; i < 64; i++) nb_map[i*4 +: 4] = 4'($urandom_range(0, 1));
            #1;
            chk("nb_random", nb_out, nb_model(int'(nb_idx), nb_map, nb_rev));
        end

        // Restart during a sweep pass
        @(negedge clk);
        start_game(map_b);
        do_cmd(1, 5, 5);
        do_cmd(0, 0, 0);
        repeat (10) @(negedge clk);
        chk("in_sweep", {busy, cmd_ready}, 2'b10);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("restart_sweep", {gen_rst, revealed, flagged}, {1'b1, 128'h0});

        // Restart with a same-cycle command
        start_game(map_b);
        do_cmd(1, 6, 6);
        chk("flag_before_restart", flagged, 64'd1 << 54);
        new_game  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_row   = 3'd2;
        cmd_col   = 3'd2;
        @(negedge clk);
        new_game  = 1'b0;
        cmd_valid = 1'b0;
        chk("restart_cmd", {gen_rst, cmd_ready, flagged, revealed}, {2'b10, 128'h0});

        // Asynchronous reset while gen_rst is high
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ctrl", {gen_rst, busy, won, lost, cmd_ready}, 0);
        chk("async_board", {map_q, revealed, flagged}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Random games against the reference model
        for (int g = 0; g < 4; g++) begin
            rmap = make_random_map(int'($urandom_range(3, 10)));
            start_game(rmap);
            chk("rnd_map", map_q, rmap);
            for (int c = 0; c < 25 && !m_lost && !m_won; c++) begin
                op  = ($urandom_range(0, 3) == 0);
                row = int'($urandom_range(0, 7));
                col = int'($urandom_range(0, 7));
                do_cmd(op, row, col);
                model_cmd(op, row, col);
                wait_settle("rnd", bc);
                chk("rnd_rev", revealed, rev_vec());
                chk("rnd_flag", flagged, flag_vec());
                chk("rnd_status", {won, lost}, {m_won, m_lost});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
